iic_slave_rx: RTL and testbench

Oversampling I2C target that receives the three-byte write transactions (device address + R/W, register address, data) issued by the team's I2C configuration master. It samples SCL/SDA with the system clock, detects START/STOP, acknowledges matching bytes by pulling SDA low, and presents the received 24-bit word with a one-cycle valid strobe. It is used as a bench-side and on-chip codec-register model, and as the receive end of the audio configuration bus.

---
 rtl/iic_slave_rx.sv | 147 ++++++++++++++
 tb/tb_iic_slave_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_rx.sv
// Oversampled I2C write target: 2-FF sync + edge register, ACKs matching bytes, emits the {addr,reg,data} word.
// Events act 3 Clk after the pin edge, SDA drive/release 4 Clk; no backpressure, Rx_Valid is a one-Clk strobe.
module iic_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IIC_Sclk,
    inout  wire         IIC_Sda,
    output logic [23:0] Rx_Data,
    output logic        Rx_Valid,
    output logic        Busy,
    output logic        Nack_Err
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, WAIT_STOP
    } state_t;

    logic        scl_s1, scl_s2, scl_d;
    logic        sda_s1, sda_s2, sda_d;
    state_t      state_q, state_n;
    logic [2:0]  bit_cnt_q, bit_cnt_n;
    logic [7:0]  shift_q, shift_n;
    logic [7:0]  addr_q, addr_n;
    logic [7:0]  reg_q, reg_n;
    logic        ack_drive_q, ack_drive_n;
    logic        sda_oe_q;
    logic [23:0] rx_data_n;
    logic        rx_valid_n, nack_err_n;

    logic        scl_rise, scl_fall, scl_high, start_evt, stop_evt;
    logic [7:0]  shift_in;

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign scl_high  = scl_s2 & scl_d;
    // Our own ACK drive must never be mistaken for a bus condition.
    assign start_evt = scl_high & sda_d & ~sda_s2 & ~sda_oe_q;
    assign stop_evt  = scl_high & ~sda_d & sda_s2 & ~sda_oe_q;
    assign shift_in  = {shift_q[6:0], sda_s2};

    assign IIC_Sda = sda_oe_q ? 1'b0 : 1'bz;
    assign Busy    = (state_q != IDLE);

    always_comb begin
        state_n     = state_q;
        bit_cnt_n   = bit_cnt_q;
        shift_n     = shift_q;
        addr_n      = addr_q;
        reg_n       = reg_q;
        ack_drive_n = ack_drive_q;
        rx_data_n   = Rx_Data;
        rx_valid_n  = 1'b0;
        nack_err_n  = 1'b0;
        if (start_evt || stop_evt) begin
            state_n     = start_evt ? ADDR : IDLE;
            bit_cnt_n   = 3'd0;
            shift_n     = 8'h00;
            ack_drive_n = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, DATA: begin
                    if (scl_rise) begin
                        shift_n   = shift_in;
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                addr_n = shift_in;
                                if (shift_in[7:1] == SLAVE_ADDR && !shift_in[0]) begin
                                    state_n = ADDR_ACK;
                                end else begin
                                    state_n    = WAIT_STOP;
                                    nack_err_n = 1'b1;
                                end
                            end else if (state_q == REG) begin
                                reg_n   = shift_in;
                                state_n = REG_ACK;
                            end else begin
                                rx_data_n  = {addr_q, reg_q, shift_in};
                                rx_valid_n = 1'b1;
                                state_n    = DATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall starts the ACK, the second ends the 9th clock.
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drive_q) begin
                            ack_drive_n = 1'b1;
                        end else begin
                            ack_drive_n = 1'b0;
                            bit_cnt_n   = 3'd0;
                            shift_n     = 8'h00;
                            case (state_q)
                                ADDR_ACK: state_n = REG;
                                REG_ACK:  state_n = DATA;
                                default:  state_n = WAIT_STOP;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            scl_s1      <= 1'b1;
            scl_s2      <= 1'b1;
            scl_d       <= 1'b1;
            sda_s1      <= 1'b1;
            sda_s2      <= 1'b1;
            sda_d       <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            addr_q      <= 8'h00;
            reg_q       <= 8'h00;
            ack_drive_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            Rx_Data     <= 24'h0;
            Rx_Valid    <= 1'b0;
            Nack_Err    <= 1'b0;
        end else begin
            scl_s1      <= IIC_Sclk;
            scl_s2      <= scl_s1;
            scl_d       <= scl_s2;
            sda_s1      <= IIC_Sda;
            sda_s2      <= sda_s1;
            sda_d       <= sda_s2;
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            shift_q     <= shift_n;
            addr_q      <= addr_n;
            reg_q       <= reg_n;
            ack_drive_q <= ack_drive_n;
            sda_oe_q    <= ack_drive_q;
            Rx_Data     <= rx_data_n;
            Rx_Valid    <= rx_valid_n;
            Nack_Err    <= nack_err_n;
        end
    end

endmodule

// File: tb/tb_iic_slave_rx.sv
// Bench for iic_slave_rx: bit-banged I2C master, transaction-level reference model, directed plus random writes.
module tb_iic_slave_rx;

    localparam logic [6:0] ADDR7 = 7'h1A;
    localparam int Q = 5;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        m_low;
    wire         iic_sda;
    logic [23:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        nack_err;

    always #5 clk = ~clk;

    pullup (iic_sda);
    assign iic_sda = m_low ? 1'b0 : 1'bz;

    iic_slave_rx #(.SLAVE_ADDR(ADDR7)) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .IIC_Sclk (scl),
        .IIC_Sda  (iic_sda),
        .Rx_Data  (rx_data),
        .Rx_Valid (rx_valid),
        .Busy     (busy),
        .Nack_Err (nack_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int valid_cnt = 0, valid_lat = 0, nack_cnt = 0, nack_lat = 0;
    bit valid_wide = 0, prev_valid = 0, prev_nack = 0, foreign = 0;
    logic [23:0] model_rx = 24'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (iic_sda === 1'b0 && !m_low) foreign = 1'b1;
    end

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_lat <= cyc - rise_cyc;
        end
        if (rx_valid && prev_valid) valid_wide <= 1'b1;
        if (nack_err && !prev_nack) begin
            nack_cnt <= nack_cnt + 1;
            nack_lat <= cyc - rise_cyc;
        end
        prev_valid <= rx_valid;
        prev_nack  <= nack_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_scl(input logic v);
        scl = v;
        if (v) rise_cyc = cyc;
    endtask

    task automatic start_c();
        m_low = 1'b0; wt(Q);
        set_scl(1'b1); wt(Q);
        m_low = 1'b1; wt(Q);
        set_scl(1'b0); wt(Q);
    endtask

    task automatic stop_c();
        m_low = 1'b1; wt(Q);
        set_scl(1'b1); wt(Q);
        m_low = 1'b0; wt(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wt(Q);
        set_scl(1'b1); wt(H);
        set_scl(1'b0); wt(Q);
    endtask

    // Sends a byte and samples SDA mid-way through the 9th clock; optionally resets the DUT there.
    task automatic write_byte(input logic [7:0] b, input bit rst_in_ack, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; wt(Q);
        set_scl(1'b1); wt(H / 2);
        ack = (iic_sda === 1'b0);
        if (rst_in_ack) begin
            rst_n = 1'b0; wt(1);
            check("ack_rst_sda_released", {31'b0, iic_sda}, 32'd1);
            check("ack_rst_busy", {31'b0, busy}, 32'd0);
            check("ack_rst_rx_data", {8'b0, rx_data}, 32'd0);
            check("ack_rst_nack", {31'b0, nack_err}, 32'd0);
            model_rx = 24'h0;
            rst_n = 1'b1;
        end
        wt(H / 2);
        set_scl(1'b0); wt(Q);
    endtask

    // Reference: address accepted iff 7-bit match and write; first three bytes ACKed, word valid after three.
    task automatic run_txn(input logic [31:0] bytes, input int n, input bit do_stop);
        int v0, n0;
        bit ok, ack, exp_valid;
        v0 = valid_cnt;
        n0 = nack_cnt;
        foreign = 1'b0;
        ok = (bytes[31:25] == ADDR7) && !bytes[24];
        exp_valid = ok && (n >= 3);
        start_c();
        check("busy_after_start", {31'b0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            write_byte(bytes[31 - 8 * i -: 8], 1'b0, ack);
            check($sformatf("ack_byte%0d", i), {31'b0, ack}, {31'b0, ok && (i < 3)});
        end
        if (exp_valid) model_rx = bytes[31:8];
        check("rx_valid_count", valid_cnt - v0, exp_valid ? 1 : 0);
        if (exp_valid) check("rx_valid_latency", valid_lat, 3);
        check("rx_valid_width", {31'b0, valid_wide}, 32'd0);
        check("nack_count", nack_cnt - n0, ok ? 0 : 1);
        if (!ok) check("nack_latency", nack_lat, 3);
        check("sda_driven", {31'b0, foreign}, {31'b0, ok});
        check("rx_data", {8'b0, rx_data}, {8'b0, model_rx});
        if (do_stop) begin
            stop_c();
            check("busy_after_stop", {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        bit a;
        int v0, n, sel;
        logic [31:0] bytes;

        rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
        wt(3);
        check("rst_rx_data", {8'b0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_nack", {31'b0, nack_err}, 32'd0);
        check("rst_sda", {31'b0, iic_sda}, 32'd1);
        rst_n = 1'b1;
        wt(5);

        run_txn(32'h340E4200, 3, 1'b1);
        run_txn(32'h36AABB00, 3, 1'b1);
        run_txn(32'h35000000, 1, 1'b1);
        run_txn(32'h340E0000, 2, 1'b0);
        run_txn(32'h34107F00, 3, 1'b1);
        run_txn(32'h340E0000, 2, 1'b1);
        run_txn(32'h34556600, 3, 1'b1);

        // Reset in the middle of the data byte.
        v0 = valid_cnt;
        start_c();
        write_byte(8'h34, 1'b0, a);
        write_byte(8'h0E, 1'b0, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        m_low = 1'b0; wt(Q);
        set_scl(1'b1); wt(2);
        rst_n = 1'b0; wt(1);
        check("data_rst_busy", {31'b0, busy}, 32'd0);
        check("data_rst_rx_data", {8'b0, rx_data}, 32'd0);
        check("data_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("data_rst_sda", {31'b0, iic_sda}, 32'd1);
        model_rx = 24'h0;
        rst_n = 1'b1; wt(2);
        set_scl(1'b0); wt(Q);
        stop_c();
        check("data_rst_no_valid", valid_cnt - v0, 0);
        run_txn(32'h3401FF00, 3, 1'b1);

        // Reset while the DUT holds SDA low for an ACK.
        start_c();
        write_byte(8'h34, 1'b0, a);
        write_byte(8'h0E, 1'b1, a);
        stop_c();
        run_txn(32'h34A5C300, 3, 1'b1);

        for (int t = 0; t < 20; t++) begin
            sel = $urandom_range(0, 3);
            bytes = $urandom;
            if (sel != 0) bytes[31:24] = 8'h34;
            n = $urandom_range(1, 4);
            run_txn(bytes, n, $urandom_range(0, 3) != 0);
        end
        stop_c();
        check("final_busy", {31'b0, busy}, 32'd0);
        check("final_rx_data", {8'b0, rx_data}, {8'b0, model_rx});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
